// File: rtl/spike_framer.sv
// spike_framer
// Watches a raw sample stream, detects threshold crossings, captures a
// FEATURES-sample window around each crossing (PRE_SAMPLES of history, the
// trigger sample, then the following samples) and streams the window out one
// sample per handshake. Spikes that arrive while a window is in flight are
// counted in a saturating drop counter.
module spike_framer #(
  parameter int FEATURES    = 3,
  parameter int IN_WIDTH    = 10,
  parameter int PRE_SAMPLES = 1,
  parameter int REFRACTORY  = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  input  logic [IN_WIDTH-1:0] in_sample,
  input  logic [IN_WIDTH-1:0] threshold,
  input  logic                out_ready,
  output logic                out_valid,
  output logic [IN_WIDTH-1:0] out_sample,
  output logic                out_last,
  output logic                busy,
  output logic [7:0]          drop_count
);

  // Samples still to be collected after the trigger sample.
  localparam int POST   = FEATURES - 1 - PRE_SAMPLES;
  localparam int IDX_W  = (FEATURES > 1) ? $clog2(FEATURES) : 1;
  localparam int REF_W  = (REFRACTORY > 0) ? $clog2(REFRACTORY + 1) : 1;
  // Keep at least one history entry so the array is never zero-sized.
  localparam int HIST_N = (PRE_SAMPLES > 0) ? PRE_SAMPLES : 1;

  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(FEATURES - 1);
  localparam logic [IDX_W-1:0] FIRST_POST = IDX_W'(PRE_SAMPLES + 1);
  localparam logic [REF_W-1:0] REF_LOAD   = REF_W'(REFRACTORY);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_POST = 2'd1,
    ST_SEND = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [IN_WIDTH-1:0] hist_q [HIST_N];
  logic [IN_WIDTH-1:0] hist_d [HIST_N];
  logic [IN_WIDTH-1:0] win_q  [FEATURES];
  logic [IN_WIDTH-1:0] win_d  [FEATURES];
  logic [IDX_W-1:0]    slot_q, slot_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [REF_W-1:0]    refract_q, refract_d;
  logic [7:0]          drop_q, drop_d;
  logic                qual_s;

  // A qualifying sample is an accepted sample at or above threshold outside
  // the refractory period; it either starts a window or becomes a drop.
  assign qual_s = in_valid && (in_sample >= threshold) && (refract_q == {REF_W{1'b0}});

  // Pre-trigger history: oldest sample at index 0, shifts on every accepted sample.
  always_comb begin
    hist_d = hist_q;
    if (in_valid) begin
      for (int i = 0; i < HIST_N - 1; i++) begin
        hist_d[i] = hist_q[i + 1];
      end
      hist_d[HIST_N-1] = in_sample;
    end else begin
      hist_d = hist_q;
    end
  end

  // Refractory counter: reload on every qualifying sample, count down on accepted samples.
  always_comb begin
    refract_d = refract_q;
    if (qual_s) begin
      refract_d = REF_LOAD;
    end else if (in_valid && (refract_q != {REF_W{1'b0}})) begin
      refract_d = refract_q - REF_W'(1);
    end else begin
      refract_d = refract_q;
    end
  end

  // Drop counter: qualifying samples seen while a window is in flight, saturating.
  always_comb begin
    drop_d = drop_q;
    if (qual_s && (state_q != ST_IDLE)) begin
      if (drop_q == 8'hFF) begin
        drop_d = 8'hFF;
      end else begin
        drop_d = drop_q + 8'd1;
      end
    end else begin
      drop_d = drop_q;
    end
  end

  // Window FSM: capture on trigger, fill post-trigger slots, then stream out.
  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    slot_d  = slot_q;
    idx_d   = idx_q;
    case (state_q)
      ST_IDLE: begin
        if (qual_s) begin
          for (int i = 0; i < PRE_SAMPLES; i++) begin
            win_d[i] = hist_q[i];
          end
          win_d[PRE_SAMPLES] = in_sample;
          idx_d = {IDX_W{1'b0}};
          if (POST == 0) begin
            state_d = ST_SEND;
          end else begin
            state_d = ST_POST;
            slot_d  = FIRST_POST;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_POST: begin
        // Every accepted sample fills the next slot, even one that also
        // counts as a drop; the window in progress is never restarted.
        if (in_valid) begin
          win_d[slot_q] = in_sample;
          if (slot_q == LAST_IDX) begin
            state_d = ST_SEND;
            idx_d   = {IDX_W{1'b0}};
          end else begin
            slot_d = slot_q + IDX_W'(1);
          end
        end else begin
          state_d = ST_POST;
        end
      end
      ST_SEND: begin
        if (out_ready) begin
          if (idx_q == LAST_IDX) begin
            state_d = ST_IDLE;
            idx_d   = {IDX_W{1'b0}};
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end else begin
          state_d = ST_SEND;
        end
      end
      default: begin
        state_d = ST_IDLE;
        idx_d   = {IDX_W{1'b0}};
      end
    endcase
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      slot_q    <= {IDX_W{1'b0}};
      idx_q     <= {IDX_W{1'b0}};
      refract_q <= {REF_W{1'b0}};
      drop_q    <= 8'd0;
      for (int i = 0; i < HIST_N; i++) begin
        hist_q[i] <= {IN_WIDTH{1'b0}};
      end
      for (int i = 0; i < FEATURES; i++) begin
        win_q[i] <= {IN_WIDTH{1'b0}};
      end
    end else begin
      state_q   <= state_d;
      slot_q    <= slot_d;
      idx_q     <= idx_d;
      refract_q <= refract_d;
      drop_q    <= drop_d;
      hist_q    <= hist_d;
      win_q     <= win_d;
    end
  end

  // Outputs are decoded purely from registered state; out_sample reads as 0
  // outside SEND so a discarded window never leaks onto the bus.
  assign out_valid  = (state_q == ST_SEND);
  assign out_sample = (state_q == ST_SEND) ? win_q[idx_q] : {IN_WIDTH{1'b0}};
  assign out_last   = (state_q == ST_SEND) && (idx_q == LAST_IDX);
  assign busy       = (state_q != ST_IDLE);
  assign drop_count = drop_q;

endmodule
